// File: rtl/uop_issue_queue.sv
// Circular uop buffer between the decoder and the backend: accepts up to ENQ_WIDTH uops per
// cycle and presents the oldest INSTR_Q_WIDTH of them. A mispredicted branch flushes everything.

package uop_pkg;

   localparam int INSTR_Q_WIDTH = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } uop_insn;

endpackage

module uop_issue_queue #(
   parameter int INSTR_Q_WIDTH = uop_pkg::INSTR_Q_WIDTH,
   parameter int ENQ_WIDTH     = 2,
   parameter int DEPTH         = 16
) (
   input  logic                                 clk_in,
   input  logic                                 rst_N_in,
   input  logic [ENQ_WIDTH-1:0]                 enq_valid_in,
   input  uop_pkg::uop_insn                     enq_uop_in [ENQ_WIDTH],
   output logic                                 enq_ready_out,
   output uop_pkg::uop_insn                     instr_queue_out [INSTR_Q_WIDTH],
   output logic [$clog2(INSTR_Q_WIDTH+1)-1:0]   deq_cnt_out,
   input  logic                                 deq_ready_in,
   input  logic                                 bcond_resolved_in,
   input  logic                                 pc_incorrect_in,
   output logic [$clog2(DEPTH+1)-1:0]           count_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DQ_W  = $clog2(INSTR_Q_WIDTH + 1);
   localparam int EQ_W  = $clog2(ENQ_WIDTH + 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   uop_pkg::uop_insn mem_q [DEPTH];

   logic             flush;
   logic             enq_fire;
   logic             deq_fire;
   logic [EQ_W-1:0]  enq_n;

   always_comb begin
      flush = bcond_resolved_in & pc_incorrect_in;
   end

   // Lanes are contiguous from lane 0, so the popcount is also the index of the first idle lane.
   always_comb begin
      enq_n = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         if (enq_valid_in[i]) begin
            enq_n = enq_n + EQ_W'(1);
         end
      end
   end

   // Readiness looks only at registered occupancy; a same-cycle dequeue earns no credit.
   always_comb begin
      enq_ready_out = !flush && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH));
      enq_fire      = enq_ready_out & enq_valid_in[0];
   end

   always_comb begin
      if (count_q >= CNT_W'(INSTR_Q_WIDTH)) begin
         deq_cnt_out = DQ_W'(INSTR_Q_WIDTH);
      end else begin
         deq_cnt_out = DQ_W'(count_q);
      end
      deq_fire  = deq_ready_in && (deq_cnt_out != '0);
      count_out = count_q;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) begin
            tail_d = tail_q + PTR_W'(enq_n);
         end
         if (deq_fire) begin
            head_d = head_q + PTR_W'(deq_cnt_out);
         end
         count_d = count_q
                 + (enq_fire ? CNT_W'(enq_n) : CNT_W'(0))
                 - (deq_fire ? CNT_W'(deq_cnt_out) : CNT_W'(0));
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; slots beyond the occupancy are masked on output.
   always_ff @(posedge clk_in) begin
      if (enq_fire) begin
         for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_valid_in[i]) begin
               mem_q[tail_q + PTR_W'(i)] <= enq_uop_in[i];
            end
         end
      end
   end

   // Unoccupied slots read as an all-zero uop so the backend never sees stale payload.
   always_comb begin
      for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
         instr_queue_out[i] = '0;
         if (DQ_W'(i) < deq_cnt_out) begin
            instr_queue_out[i]       = mem_q[head_q + PTR_W'(i)];
            instr_queue_out[i].valid = 1'b1;
         end
      end
   end

   a_enq_contiguous : assert property (@(posedge clk_in) disable iff (!rst_N_in)
      (enq_valid_in & (enq_valid_in + ENQ_WIDTH'(1))) == '0);

   a_count_bound : assert property (@(posedge clk_in) disable iff (!rst_N_in)
      count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed bench for uop_issue_queue: a vector table for single-cycle behaviour plus
// hand-written sequences for fill, pointer wrap, flush and reset corner cases.

module tb_uop_issue_queue;
   import uop_pkg::*;

   localparam int IQW   = 4;
   localparam int EW    = 2;
   localparam int DEPTH = 16;
   localparam int NV    = 9;

   logic          clk_in = 1'b0;
   logic          rst_N_in = 1'b0;
   logic [EW-1:0] enq_valid_in;
   uop_insn       enq_uop_in [EW];
   logic          enq_ready_out;
   uop_insn       instr_queue_out [IQW];
   logic [2:0]    deq_cnt_out;
   logic          deq_ready_in;
   logic          bcond_resolved_in;
   logic          pc_incorrect_in;
   logic [4:0]    count_out;

   int errors = 0;
   int checks = 0;

   uop_issue_queue #(.INSTR_Q_WIDTH(IQW), .ENQ_WIDTH(EW), .DEPTH(DEPTH)) dut (
      .clk_in            (clk_in),
      .rst_N_in          (rst_N_in),
      .enq_valid_in      (enq_valid_in),
      .enq_uop_in        (enq_uop_in),
      .enq_ready_out     (enq_ready_out),
      .instr_queue_out   (instr_queue_out),
      .deq_cnt_out       (deq_cnt_out),
      .deq_ready_in      (deq_ready_in),
      .bcond_resolved_in (bcond_resolved_in),
      .pc_incorrect_in   (pc_incorrect_in),
      .count_out         (count_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [1:0]  ev;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        deq;
      logic        bc;
      logic        pi;
      logic        rdy;
      logic [4:0]  cnt;
      logic [2:0]  dq;
      logic [31:0] s0pc;
   } vec_t;

   vec_t vecs [NV];

   logic [31:0] model [$];
   logic [31:0] next_pc;
   logic [31:0] exp_rx;
   int          sent;
   int          rcvd;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Payload fields derive from the pc so a mixed-up slot or lane shows up in any field.
   function automatic uop_insn mk_in(input logic [31:0] pc);
      uop_insn u;
      u        = '0;
      u.pc     = pc;
      u.opcode = 7'h33 ^ pc[8:2];
      u.rd     = pc[6:2];
      u.rs1    = pc[11:7];
      u.rs2    = pc[16:12];
      u.imm    = ~pc;
      u.valid  = 1'b0;
      return u;
   endfunction

   function automatic uop_insn exp_uop(input logic [31:0] pc);
      uop_insn u;
      u       = mk_in(pc);
      u.valid = 1'b1;
      return u;
   endfunction

   task automatic drive(input logic [1:0] ev, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic deq, input logic bc, input logic pi);
      enq_valid_in      = ev;
      enq_uop_in[0]     = mk_in(pc0);
      enq_uop_in[1]     = mk_in(pc1);
      deq_ready_in      = deq;
      bcond_resolved_in = bc;
      pc_incorrect_in   = pi;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One scoreboard cycle: compare the presented bundle against the model, then advance it.
   task automatic sb_cycle(input logic do_enq);
      int      sz;
      int      dq;
      logic    rdy;
      uop_insn e;
      sz  = model.size();
      dq  = (sz < IQW) ? sz : IQW;
      rdy = ((DEPTH - sz) >= EW);
      check("sb_count", count_out, sz);
      check("sb_count_max", count_out <= 5'd16, 1'b1);
      check("sb_deq_cnt", deq_cnt_out, dq);
      for (int j = 0; j < IQW; j++) begin
         e = '0;
         if (j < dq) e = exp_uop(model[j]);
         check($sformatf("sb_slot%0d", j), instr_queue_out[j], e);
      end
      for (int j = 0; j < dq; j++) begin
         check("sb_order", instr_queue_out[j].pc, exp_rx);
         exp_rx = exp_rx + 32'd4;
         rcvd++;
      end
      drive(do_enq ? 2'b11 : 2'b00, next_pc, next_pc + 32'd4, 1'b1, 1'b0, 1'b0);
      #1;
      check("sb_rdy", enq_ready_out, rdy);
      repeat (dq) void'(model.pop_front());
      if (do_enq && rdy) begin
         model.push_back(next_pc);
         model.push_back(next_pc + 32'd4);
         next_pc = next_pc + 32'd8;
         sent += 2;
      end
      step();
   endtask

   initial begin
      //                 ev     pc0         pc1         deq   bc    pi    rdy   cnt    dq    s0pc
      vecs[0] = '{2'b01, 32'h1000, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 3'd1, 32'h1000};
      vecs[1] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 32'h0};
      vecs[2] = '{2'b11, 32'h100,  32'h104,  1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 3'd2, 32'h100};
      vecs[3] = '{2'b11, 32'h108,  32'h10C,  1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 3'd4, 32'h100};
      vecs[4] = '{2'b01, 32'h110,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 3'd1, 32'h110};
      vecs[5] = '{2'b11, 32'h114,  32'h118,  1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 3'd2, 32'h114};
      vecs[6] = '{2'b00, 32'h0,    32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 3'd2, 32'h114};
      vecs[7] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 3'd0, 32'h0};
      vecs[8] = '{2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 32'h0};

      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst_N_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_N_in = 1'b1;
      #1;
      check("rst_count", count_out, 5'd0);
      check("rst_deq_cnt", deq_cnt_out, 3'd0);
      check("rst_rdy", enq_ready_out, 1'b1);
      for (int j = 0; j < IQW; j++) begin
         check($sformatf("rst_slot%0d", j), instr_queue_out[j], 82'h0);
      end
      step();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ev, vecs[i].pc0, vecs[i].pc1, vecs[i].deq, vecs[i].bc, vecs[i].pi);
         #1;
         check($sformatf("v%0d_rdy", i), enq_ready_out, vecs[i].rdy);
         step();
         check($sformatf("v%0d_count", i), count_out, vecs[i].cnt);
         check($sformatf("v%0d_deq_cnt", i), deq_cnt_out, vecs[i].dq);
         check($sformatf("v%0d_s0pc", i), instr_queue_out[0].pc, vecs[i].s0pc);
         for (int j = 0; j < IQW; j++) begin
            check($sformatf("v%0d_valid%0d", i, j), instr_queue_out[j].valid, j < int'(vecs[i].dq));
         end
      end
      check("v0_slot1_zero", 1'b0, instr_queue_out[1].valid);

      // Fill to full: pointers start mid-array, so the fill wraps.
      for (int k = 0; k < 8; k++) begin
         drive(2'b11, 32'(8 * k), 32'(8 * k + 4), 1'b0, 1'b0, 1'b0);
         #1;
         check($sformatf("fill%0d_rdy", k), enq_ready_out, 1'b1);
         step();
      end
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("full_count", count_out, 5'd16);
      check("full_rdy", enq_ready_out, 1'b0);
      for (int j = 0; j < IQW; j++) begin
         check($sformatf("full_slot%0d", j), instr_queue_out[j], exp_uop(32'(4 * j)));
      end
      drive(2'b11, 32'h40, 32'h44, 1'b0, 1'b0, 1'b0);
      #1;
      check("full_offer_rdy", enq_ready_out, 1'b0);
      step();
      check("full_offer_count", count_out, 5'd16);
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         #1;
         check($sformatf("drain%0d_s0pc", k), instr_queue_out[0].pc, 32'(16 * k));
         step();
      end
      check("drain_count", count_out, 5'd0);

      // Concurrent enqueue and dequeue across the pointer wrap.
      next_pc = 32'h3000;
      exp_rx  = 32'h3000;
      sent    = 0;
      rcvd    = 0;
      for (int k = 0; k < 20; k++) sb_cycle(1'b1);
      for (int k = 0; k < 8 && model.size() != 0; k++) sb_cycle(1'b0);
      check("sb_empty", count_out, 5'd0);
      check("sb_total", rcvd, sent);

      // Flush wins over the same-cycle enqueue and dequeue.
      for (int k = 0; k < 5; k++) begin
         drive(2'b11, 32'h4000 + 32'(8 * k), 32'h4004 + 32'(8 * k), 1'b0, 1'b0, 1'b0);
         step();
      end
      check("pre_flush_count", count_out, 5'd10);
      drive(2'b11, 32'h5000, 32'h5004, 1'b1, 1'b1, 1'b1);
      #1;
      check("flush_rdy", enq_ready_out, 1'b0);
      step();
      check("flush_count", count_out, 5'd0);
      check("flush_deq_cnt", deq_cnt_out, 3'd0);
      check("flush_slot0", instr_queue_out[0], 82'h0);
      drive(2'b01, 32'h2000, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("post_flush_deq_cnt", deq_cnt_out, 3'd1);
      check("post_flush_slot0", instr_queue_out[0], exp_uop(32'h2000));
      check("post_flush_slot1", instr_queue_out[1].valid, 1'b0);

      // A correctly predicted branch resolve leaves the contents alone.
      drive(2'b11, 32'h2004, 32'h2008, 1'b0, 1'b0, 1'b0);
      step();
      drive(2'b11, 32'h200C, 32'h2010, 1'b0, 1'b0, 1'b0);
      step();
      check("nf_pre_count", count_out, 5'd5);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      check("nf_count", count_out, 5'd5);
      check("nf_slot0", instr_queue_out[0], exp_uop(32'h2000));
      check("nf_slot3", instr_queue_out[3], exp_uop(32'h200C));
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      step();
      check("nf_deq_count", count_out, 5'd1);
      check("nf_deq_slot0", instr_queue_out[0], exp_uop(32'h2010));

      // Asynchronous reset in the middle of operation discards the remaining entry.
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      rst_N_in = 1'b0;
      #1;
      check("mid_rst_count", count_out, 5'd0);
      check("mid_rst_deq_cnt", deq_cnt_out, 3'd0);
      check("mid_rst_slot0", instr_queue_out[0], 82'h0);
      @(negedge clk_in);
      rst_N_in = 1'b1;
      #1;
      check("mid_rst_rdy", enq_ready_out, 1'b1);
      drive(2'b01, 32'h6000, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("mid_rst_enq", instr_queue_out[0], exp_uop(32'h6000));
      check("mid_rst_enq_count", count_out, 5'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Circular buffer between decode and `backend`. Accepts up to ENQ_WIDTH decoded `uop_pkg::uop_insn` entries per cycle from the decoder.
- Presents the oldest INSTR_Q_WIDTH entries to `backend` as its `instr_queue` bundle.
- Flushes all buffered uops when `backend` reports a resolved mispredicted branch.
- Drives the `instr_queue` input of `backend`, replacing the hand-built bundle used in bench setups.

Parameters:
- INSTR_Q_WIDTH, uop_pkg::INSTR_Q_WIDTH (4): uops presented to backend per cycle.
- ENQ_WIDTH, 2: decoder lanes per cycle.
- DEPTH, 16: buffer entries; power of two, DEPTH >= INSTR_Q_WIDTH + ENQ_WIDTH.

Ports:
- clk_in  input  1  clock.
- rst_N_in  input  1  asynchronous active-low reset.
- enq_valid_in  input  ENQ_WIDTH  per-lane valid; contiguous from lane 0.
- enq_uop_in  input  ENQ_WIDTH x $bits(uop_insn)  decoded uops; lane 0 oldest.
- enq_ready_out  output  1  queue can accept a full ENQ_WIDTH bundle this cycle.
- instr_queue_out  output  INSTR_Q_WIDTH x $bits(uop_insn)  oldest uops; slot 0 oldest.
- deq_cnt_out  output  $clog2(INSTR_Q_WIDTH+1)  number of valid slots presented.
- deq_ready_in  input  1  backend consumes all presented slots this cycle.
- bcond_resolved_in  input  1  from backend bcond_resolved_out.
- pc_incorrect_in  input  1  from backend pc_incorrect_out.
- count_out  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH-entry array, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy count of $clog2(DEPTH+1) bits. Storage contents are not reset.
- Reset (async, rst_N_in=0):
  - head=tail=count=0, so count_out=0 and deq_cnt_out=0.
  - All instr_queue_out slots read all-zero with valid=0.
  - enq_ready_out=1 once reset deasserts. Reset mid-operation discards all entries.
- flush = bcond_resolved_in & pc_incorrect_in.
- enq_ready_out is combinational: (DEPTH - count) >= ENQ_WIDTH, computed from the registered count. It is forced to 0 in any cycle where flush=1.
- Enqueue fires when enq_ready_out=1 and enq_valid_in[0]=1.
  - Writes the n = popcount(enq_valid_in) lanes to tail..tail+n-1 (mod DEPTH).
  - tail += n.
  - Non-contiguous enq_valid_in is illegal; the design asserts on it in simulation.
  - Lanes offered while enq_ready_out=0 are dropped; the decoder must hold them.
- Presentation is combinational from registered state.
  - deq_cnt_out = min(count, INSTR_Q_WIDTH).
  - Slot i < deq_cnt_out: entry at head+i (mod DEPTH), valid field forced to 1.
  - Slot i >= deq_cnt_out: all-zero uop with valid=0. Never filled with UOP_HLT.
- Dequeue fires when deq_ready_in=1 and deq_cnt_out>0: head += deq_cnt_out. deq_ready_in with deq_cnt_out=0 has no effect.
- Simultaneous enqueue and dequeue in the same cycle:
  - count_next = count + n - deq_cnt_out.
  - enq_ready_out does not credit the same-cycle dequeue.
  - A bypass path is not provided: an entry enqueued in cycle t is first presented in cycle t+1. Minimum latency is 1 cycle.
- Flush has priority over enqueue and dequeue in the same cycle.
  - Next cycle: head=tail=count=0 and deq_cnt_out=0.
  - Enqueue lanes in the flush cycle are dropped, because enq_ready_out is 0.
  - bcond_resolved_in alone, or pc_incorrect_in alone, does nothing.
- Invariants: count never exceeds DEPTH and never underflows. count_out always equals (tail - head) mod DEPTH, except count=DEPTH where head==tail.

Test Plan:
- Reset then idle: hold rst_N_in=0 for 2 cycles, release -> count_out=0, deq_cnt_out=0, all slots valid=0, enq_ready_out=1.
- Single enqueue, latency:
  - Stimulus: cycle 0, enq_valid_in=2'b01 with pc=0x1000, deq_ready_in=0.
  - Cycle 1: deq_cnt_out=1, slot0.pc=0x1000, slots 1-3 valid=0.
  - Assert deq_ready_in in cycle 1 -> count_out=0 in cycle 2.
- Fill to full:
  - Stimulus: 8 cycles of enq_valid_in=2'b11 with pcs 0x0,0x4,...,0x3C, no dequeue.
  - count_out=16 and enq_ready_out=0; a 9th offer is not accepted.
  - Slots present pcs 0x0,0x4,0x8,0xC.
- Wrap-around with concurrent traffic:
  - Stimulus: 20 cycles of enq 2'b11 plus deq_ready_in=1.
  - Backend receives pcs in strict program order across the pointer wrap.
  - count_out stays <= 16, and no uop is lost or duplicated (scoreboard check).
- Flush priority:
  - Stimulus: with count=10, one cycle of bcond_resolved_in=1, pc_incorrect_in=1, deq_ready_in=1, enq 2'b11.
  - enq_ready_out=0 in that cycle; next cycle count_out=0 and deq_cnt_out=0.
  - Next enqueue of pc=0x2000 is presented alone in slot0.
- Non-flush branch resolve: bcond_resolved_in=1, pc_incorrect_in=0 with count=5 -> count_out=5, or 1 if dequeued that cycle; contents unchanged.
